// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file read-port arbiter.
// Imported by the picker, the arbiter top and its bench.
package rf_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;

   typedef enum logic {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } rf_arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: rotate the valid vector to start at ptr,
// find the first set bit, then map it back to a requester index.
module rr_priority_picker #(
   parameter int N_REQ = 4,
   parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] valid,
   input  logic [PW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PW-1:0]    index
);

   logic [N_REQ-1:0] rot;
   logic             hit;
   int               off;

   always_comb begin
      rot = '0;
      for (int k = 0; k < N_REQ; k++) begin
         rot[k] = valid[PW'((int'(ptr) + k) % N_REQ)];
      end
      hit = 1'b0;
      off = 0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!hit && rot[k]) begin
            hit = 1'b1;
            off = k;
         end
      end
      index = PW'((int'(ptr) + off) % N_REQ);
      grant = '0;
      if (hit) grant[index] = 1'b1;
   end

endmodule

// File: rtl/regfile_read_arbiter.sv
// Shares the single register-file read port among N_REQ requesters
// with round-robin priority and an optional bounded lock.
module regfile_read_arbiter
   import rf_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [REG_ADDR_W*N_REQ-1:0] req_addr,
   input  logic [N_REQ-1:0]            req_lock,
   output logic [N_REQ-1:0]            req_ready,
   input  logic                        port_busy,
   output logic [REG_ADDR_W-1:0]       rf_sel,
   input  logic [XLEN-1:0]             rf_data,
   output logic [N_REQ-1:0]            resp_valid,
   output logic [XLEN-1:0]             resp_data
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   rf_arb_state_t    state;
   logic [PW-1:0]    rr_ptr;
   logic [PW-1:0]    owner;
   logic [PW-1:0]    win_idx;
   logic [3:0]       burst_cnt;
   logic [N_REQ-1:0] pick_grant;
   logic [N_REQ-1:0] grant;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] i);
      return (i == PW'(N_REQ - 1)) ? '0 : i + 1'b1;
   endfunction

   rr_priority_picker #(
      .N_REQ(N_REQ),
      .PW   (PW)
   ) u_pick (
      .valid(req_valid),
      .ptr  (rr_ptr),
      .grant(pick_grant),
      .index(win_idx)
   );

   // A locked owner that drops valid gets nothing and nobody else
   // is served that cycle; arbitration resumes next cycle.
   always_comb begin
      grant = '0;
      if (!reset && !port_busy) begin
         if (state == LOCKED) begin
            if (req_valid[owner]) grant[owner] = 1'b1;
         end else begin
            grant = pick_grant;
         end
      end
   end

   always_comb begin
      rf_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) rf_sel = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
      end
   end

   assign req_ready = grant;

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ARB;
         rr_ptr     <= '0;
         owner      <= '0;
         burst_cnt  <= '0;
         resp_valid <= '0;
         resp_data  <= '0;
      end else begin
         resp_valid <= grant;
         if (|grant) resp_data <= rf_data;
         if (!port_busy) begin
            unique case (state)
               ARB: begin
                  if (|pick_grant) begin
                     rr_ptr <= nxt(win_idx);
                     if (req_lock[win_idx] && MAX_BURST > 1) begin
                        state     <= LOCKED;
                        owner     <= win_idx;
                        burst_cnt <= 4'd1;
                     end
                  end
               end
               LOCKED: begin
                  if (!req_valid[owner] || !req_lock[owner] ||
                      burst_cnt == 4'(MAX_BURST - 1)) begin
                     state     <= ARB;
                     burst_cnt <= '0;
                     rr_ptr    <= nxt(owner);
                  end else begin
                     burst_cnt <= burst_cnt + 4'd1;
                  end
               end
               default: state <= ARB;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Directed bench for regfile_read_arbiter with a simple register-file
// model behind rf_sel.
module tb_regfile_read_arbiter;
   import rf_pkg::*;

   localparam int N = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic [N-1:0]  req_valid;
   logic [5*N-1:0] req_addr;
   logic [N-1:0]  req_lock;
   logic [N-1:0]  req_ready;
   logic          port_busy;
   logic [4:0]    rf_sel;
   logic [31:0]   rf_data;
   logic [N-1:0]  resp_valid;
   logic [31:0]   resp_data;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   function automatic logic [31:0] rfv(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : {16'hBEEF, 11'h0, a};
   endfunction

   assign rf_data = rfv(rf_sel);

   regfile_read_arbiter #(
      .N_REQ    (N),
      .MAX_BURST(4)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_lock  (req_lock),
      .req_ready (req_ready),
      .port_busy (port_busy),
      .rf_sel    (rf_sel),
      .rf_data   (rf_data),
      .resp_valid(resp_valid),
      .resp_data (resp_data)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // advance one cycle; inputs are driven 1 time unit after the edge
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // sample 1 unit after driving, well away from either edge
   task automatic cyc(input string tag, input logic [3:0] rdy,
                      input logic [4:0] sel, input logic [3:0] rv,
                      input logic [31:0] rd);
      #1;
      chk({tag, ".ready"}, 32'(req_ready), 32'(rdy));
      chk({tag, ".onehot"}, 32'($onehot0(req_ready)), 32'd1);
      chk({tag, ".sel"}, 32'(rf_sel), 32'(sel));
      chk({tag, ".rvalid"}, 32'(resp_valid), 32'(rv));
      chk({tag, ".rdata"}, resp_data, rd);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 4'b1111;
      req_lock  = 4'b0000;
      port_busy = 1'b0;
      req_addr  = {5'd4, 5'd3, 5'd2, 5'd1};
      step();
      step();
      cyc("rst", 4'b0000, 5'd0, 4'b0000, 32'h0);
      chk("rst.state", 32'(dut.state), 32'(ARB));
      chk("rst.ptr", 32'(dut.rr_ptr), 32'd0);
      chk("rst.burst", 32'(dut.burst_cnt), 32'd0);

      // 1: round robin over all requesters
      reset = 1'b0;
      cyc("rr0", 4'b0001, 5'd1, 4'b0000, 32'h0);
      step();
      cyc("rr1", 4'b0010, 5'd2, 4'b0001, rfv(5'd1));
      step();
      cyc("rr2", 4'b0100, 5'd3, 4'b0010, rfv(5'd2));
      step();
      cyc("rr3", 4'b1000, 5'd4, 4'b0100, rfv(5'd3));
      step();
      cyc("rr4", 4'b0001, 5'd1, 4'b1000, rfv(5'd4));
      step();

      // 2: requester 2 locks for a full burst while 0 waits
      req_valid = 4'b0101;
      req_lock  = 4'b0100;
      cyc("lk0", 4'b0100, 5'd3, 4'b0001, rfv(5'd1));
      step();
      chk("lk1.state", 32'(dut.state), 32'(LOCKED));
      chk("lk1.burst", 32'(dut.burst_cnt), 32'd1);
      cyc("lk1", 4'b0100, 5'd3, 4'b0100, rfv(5'd3));
      step();
      cyc("lk2", 4'b0100, 5'd3, 4'b0100, rfv(5'd3));
      step();
      chk("lk3.burst", 32'(dut.burst_cnt), 32'd3);
      cyc("lk3", 4'b0100, 5'd3, 4'b0100, rfv(5'd3));
      step();
      chk("lk4.state", 32'(dut.state), 32'(ARB));
      chk("lk4.burst", 32'(dut.burst_cnt), 32'd0);
      chk("lk4.ptr", 32'(dut.rr_ptr), 32'd3);
      cyc("lk4", 4'b0001, 5'd1, 4'b0100, rfv(5'd3));
      step();

      // 3: port busy blocks everything and freezes the pointer
      req_valid = 4'b1010;
      req_lock  = 4'b0000;
      port_busy = 1'b1;
      cyc("bz0", 4'b0000, 5'd0, 4'b0001, rfv(5'd1));
      step();
      cyc("bz1", 4'b0000, 5'd0, 4'b0000, rfv(5'd1));
      step();
      cyc("bz2", 4'b0000, 5'd0, 4'b0000, rfv(5'd1));
      chk("bz2.ptr", 32'(dut.rr_ptr), 32'd1);
      step();
      port_busy = 1'b0;
      cyc("bz3", 4'b0010, 5'd2, 4'b0000, rfv(5'd1));
      step();

      // 4: locked owner 1 drops valid mid-burst
      req_valid = 4'b0010;
      req_lock  = 4'b0010;
      cyc("dr0", 4'b0010, 5'd2, 4'b0010, rfv(5'd2));
      step();
      req_valid = 4'b0011;
      cyc("dr1", 4'b0010, 5'd2, 4'b0010, rfv(5'd2));
      step();
      req_valid = 4'b0001;
      req_lock  = 4'b0000;
      cyc("dr2", 4'b0000, 5'd0, 4'b0010, rfv(5'd2));
      step();
      chk("dr3.state", 32'(dut.state), 32'(ARB));
      cyc("dr3", 4'b0001, 5'd1, 4'b0000, rfv(5'd2));
      step();

      // 5: reset the cycle after an accept of x5
      req_addr = {5'd4, 5'd3, 5'd2, 5'd5};
      cyc("rs0", 4'b0001, 5'd5, 4'b0001, rfv(5'd1));
      step();
      reset = 1'b1;
      cyc("rs1", 4'b0000, 5'd0, 4'b0001, rfv(5'd5));
      step();
      reset     = 1'b0;
      req_valid = 4'b0000;
      cyc("rs2", 4'b0000, 5'd0, 4'b0000, 32'h0);
      chk("rs2.state", 32'(dut.state), 32'(ARB));
      chk("rs2.ptr", 32'(dut.rr_ptr), 32'd0);
      step();

      // 6: back-to-back x0 then x31 from one requester
      req_valid = 4'b0001;
      req_addr  = {5'd4, 5'd3, 5'd2, 5'd0};
      cyc("x0", 4'b0001, 5'd0, 4'b0000, 32'h0);
      step();
      req_addr = {5'd4, 5'd3, 5'd2, 5'd31};
      cyc("x31", 4'b0001, 5'd31, 4'b0001, 32'h0);
      step();
      req_valid = 4'b0000;
      cyc("x31r", 4'b0000, 5'd0, 4'b0001, 32'hBEEF_001F);
      step();
      cyc("hold", 4'b0000, 5'd0, 4'b0000, 32'hBEEF_001F);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
